// File: rtl/hazard_scoreboard_unit.sv
// Hazard and scoreboard unit for the ID/EX stages.
// Produces per-operand ALU forward selects, detects load-use, RAW/WAW
// scoreboard and multi-cycle structural hazards, and keeps a
// saturating count of stalled cycles.
module hazard_scoreboard_unit #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [ADDR_W-1:0]         id_rd_addr,
    input  logic                      id_rd_we,
    input  logic                      id_is_md,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] ex_rs_addr,
    input  logic [ADDR_W-1:0]         id_ex_rd_addr,
    input  logic                      id_ex_mem_read,
    input  logic [ADDR_W-1:0]         ex_mem_rd_addr,
    input  logic                      ex_mem_reg_write_en,
    input  logic [ADDR_W-1:0]         mem_wb_rd_addr,
    input  logic                      mem_wb_reg_write_en,
    input  logic                      md_issue,
    input  logic [ADDR_W-1:0]         md_issue_rd,
    input  logic                      md_done,
    input  logic [ADDR_W-1:0]         md_done_rd,
    input  logic                      flush,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      bubble,
    output logic                      md_busy,
    output logic [(2**ADDR_W)-1:0]    sb_pending,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int NUM_REGS = 2**ADDR_W;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;

    localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0]  sb_pending_r;
    logic                 md_busy_r;
    logic [CNT_W-1:0]     stall_cnt_r;

    logic [2*NUM_SRC-1:0] fwd_sel_s;
    logic                 load_use_s;
    logic                 raw_s;
    logic                 waw_s;
    logic                 struct_s;
    logic                 stall_s;
    logic [NUM_REGS-1:0]  sb_next_s;
    logic                 md_busy_next_s;

    // Forward select per EX operand: EX/MEM beats MEM/WB, x0 never forwards.
    always_comb begin
        fwd_sel_s = {(2*NUM_SRC){1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_mem_reg_write_en && (ex_mem_rd_addr != REG_ZERO) &&
                (ex_mem_rd_addr == ex_rs_addr[k*ADDR_W +: ADDR_W])) begin
                fwd_sel_s[2*k +: 2] = FWD_EXM;
            end else if (mem_wb_reg_write_en && (mem_wb_rd_addr != REG_ZERO) &&
                         (mem_wb_rd_addr == ex_rs_addr[k*ADDR_W +: ADDR_W])) begin
                fwd_sel_s[2*k +: 2] = FWD_MWB;
            end else begin
                fwd_sel_s[2*k +: 2] = FWD_RF;
            end
        end
    end

    // Hazard detection on the ID instruction; pending checks see registered state only.
    always_comb begin
        load_use_s = 1'b0;
        raw_s      = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            load_use_s = load_use_s |
                         (id_rs_used[k] & id_ex_mem_read &
                          (id_ex_rd_addr != REG_ZERO) &
                          (id_ex_rd_addr == id_rs_addr[k*ADDR_W +: ADDR_W]));
            raw_s      = raw_s |
                         (id_rs_used[k] & sb_pending_r[id_rs_addr[k*ADDR_W +: ADDR_W]]);
        end
        waw_s    = id_rd_we & (id_rd_addr != REG_ZERO) & sb_pending_r[id_rd_addr];
        struct_s = id_is_md & md_busy_r;
        stall_s  = id_valid & (load_use_s | raw_s | waw_s | struct_s) & ~flush;
    end

    // Next scoreboard and busy state: a set on the same register wins over a clear.
    always_comb begin
        sb_next_s = sb_pending_r;
        if (md_done) begin
            sb_next_s[md_done_rd] = 1'b0;
        end else begin
            sb_next_s = sb_pending_r;
        end
        if (md_issue && (md_issue_rd != REG_ZERO)) begin
            sb_next_s[md_issue_rd] = 1'b1;
        end else begin
            sb_next_s[0] = sb_next_s[0];
        end
        sb_next_s[0] = 1'b0;

        if (md_issue) begin
            md_busy_next_s = 1'b1;
        end else if (md_done) begin
            md_busy_next_s = 1'b0;
        end else begin
            md_busy_next_s = md_busy_r;
        end
    end

    // Scoreboard, busy flag and saturating stall counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_pending_r <= {NUM_REGS{1'b0}};
            md_busy_r    <= 1'b0;
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            sb_pending_r <= sb_next_s;
            md_busy_r    <= md_busy_next_s;
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign fwd_sel    = fwd_sel_s;
    assign stall      = stall_s;
    assign bubble     = stall_s;
    assign md_busy    = md_busy_r;
    assign sb_pending = sb_pending_r;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: a table of combinational
// forward/load-use vectors followed by directed multi-cycle sequences.
module tb_hazard_scoreboard_unit;

    localparam int NS = 2;
    localparam int AW = 5;
    localparam int CW = 4;

    logic             clk;
    logic             rst_n;
    logic [NS*AW-1:0] id_rs_addr;
    logic [NS-1:0]    id_rs_used;
    logic [AW-1:0]    id_rd_addr;
    logic             id_rd_we;
    logic             id_is_md;
    logic             id_valid;
    logic [NS*AW-1:0] ex_rs_addr;
    logic [AW-1:0]    id_ex_rd_addr;
    logic             id_ex_mem_read;
    logic [AW-1:0]    ex_mem_rd_addr;
    logic             ex_mem_reg_write_en;
    logic [AW-1:0]    mem_wb_rd_addr;
    logic             mem_wb_reg_write_en;
    logic             md_issue;
    logic [AW-1:0]    md_issue_rd;
    logic             md_done;
    logic [AW-1:0]    md_done_rd;
    logic             flush;
    logic [2*NS-1:0]  fwd_sel;
    logic             stall;
    logic             bubble;
    logic             md_busy;
    logic [31:0]      sb_pending;
    logic [CW-1:0]    stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard_unit #(.NUM_SRC(NS), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_is_md(id_is_md), .id_valid(id_valid),
        .ex_rs_addr(ex_rs_addr), .id_ex_rd_addr(id_ex_rd_addr),
        .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_reg_write_en(ex_mem_reg_write_en),
        .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_reg_write_en(mem_wb_reg_write_en),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .md_done(md_done), .md_done_rd(md_done_rd),
        .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble),
        .md_busy(md_busy), .sb_pending(sb_pending), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] ex_rs;
        logic [9:0] id_rs;
        logic [1:0] used;
        logic [4:0] idex_rd;
        logic       idex_ld;
        logic [4:0] exm_rd;
        logic       exm_we;
        logic [4:0] mwb_rd;
        logic       mwb_we;
        logic       idv;
        logic       fl;
        logic [3:0] exp_fwd;
        logic       exp_stall;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs_addr = 10'd0; id_rs_used = 2'b00; id_rd_addr = 5'd0; id_rd_we = 1'b0;
        id_is_md = 1'b0; id_valid = 1'b0; ex_rs_addr = 10'd0;
        id_ex_rd_addr = 5'd0; id_ex_mem_read = 1'b0;
        ex_mem_rd_addr = 5'd0; ex_mem_reg_write_en = 1'b0;
        mem_wb_rd_addr = 5'd0; mem_wb_reg_write_en = 1'b0;
        md_issue = 1'b0; md_issue_rd = 5'd0; md_done = 1'b0; md_done_rd = 5'd0;
        flush = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // {ex_rs, id_rs, used, idex_rd, idex_ld, exm_rd, exm_we, mwb_rd, mwb_we, idv, fl, fwd, stall}
        vecs[0]  = '{{5'd0, 5'd5}, 10'd0, 2'b00, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0};
        vecs[1]  = '{{5'd0, 5'd5}, 10'd0, 2'b00, 5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0};
        vecs[2]  = '{{5'd0, 5'd0}, 10'd0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[3]  = '{{5'd3, 5'd9}, 10'd0, 2'b00, 5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0};
        vecs[4]  = '{{5'd4, 5'd4}, 10'd0, 2'b00, 5'd0, 1'b0, 5'd4, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0};
        vecs[5]  = '{10'd0, {5'd7, 5'd1}, 2'b11, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1};
        vecs[6]  = '{10'd0, {5'd7, 5'd1}, 2'b01, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        vecs[7]  = '{10'd0, {5'd7, 5'd1}, 2'b11, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[8]  = '{10'd0, {5'd7, 5'd1}, 2'b11, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[9]  = '{10'd0, {5'd2, 5'd0}, 2'b11, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        vecs[10] = '{10'd0, {5'd7, 5'd1}, 2'b11, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};

        rst_n = 1'b1;
        idle_inputs();
        do_reset();
        check("reset_sb", 64'(sb_pending), 64'd0);
        check("reset_busy", 64'(md_busy), 64'd0);
        check("reset_cnt", 64'(stall_cnt), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);

        // Table: forwarding and load-use, no clock edges so state stays clear.
        for (int i = 0; i < 11; i++) begin
            ex_rs_addr = vecs[i].ex_rs; id_rs_addr = vecs[i].id_rs; id_rs_used = vecs[i].used;
            id_ex_rd_addr = vecs[i].idex_rd; id_ex_mem_read = vecs[i].idex_ld;
            ex_mem_rd_addr = vecs[i].exm_rd; ex_mem_reg_write_en = vecs[i].exm_we;
            mem_wb_rd_addr = vecs[i].mwb_rd; mem_wb_reg_write_en = vecs[i].mwb_we;
            id_valid = vecs[i].idv; flush = vecs[i].fl;
            #1;
            check($sformatf("vec%0d_fwd", i), 64'(fwd_sel), 64'(vecs[i].exp_fwd));
            check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
            check($sformatf("vec%0d_bubble", i), 64'(bubble), 64'(vecs[i].exp_stall));
        end

        // Load-use lasts one cycle once the bubble reaches ID/EX.
        do_reset();
        id_valid = 1'b1; id_rs_addr = {5'd7, 5'd1}; id_rs_used = 2'b11;
        id_ex_rd_addr = 5'd7; id_ex_mem_read = 1'b1;
        #1;
        check("lu_stall", 64'(stall), 64'd1);
        tick();
        id_ex_rd_addr = 5'd0; id_ex_mem_read = 1'b0;
        #1;
        check("lu_release", 64'(stall), 64'd0);
        check("lu_cnt", 64'(stall_cnt), 64'd1);

        // RAW on a pending divide result, released the cycle after md_done.
        do_reset();
        md_issue = 1'b1; md_issue_rd = 5'd10;
        tick();
        md_issue = 1'b0;
        check("md_sb_set", 64'(sb_pending), 64'h400);
        check("md_busy_set", 64'(md_busy), 64'd1);
        id_valid = 1'b1; id_rs_addr = {5'd0, 5'd10}; id_rs_used = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("raw_stall%0d", c), 64'(stall), 64'd1);
            tick();
        end
        md_done = 1'b1; md_done_rd = 5'd10;
        #1;
        check("raw_stall_done_cycle", 64'(stall), 64'd1);
        tick();
        md_done = 1'b0;
        #1;
        check("raw_release", 64'(stall), 64'd0);
        check("raw_cnt", 64'(stall_cnt), 64'd4);
        check("raw_sb_clear", 64'(sb_pending), 64'd0);
        check("raw_busy_clear", 64'(md_busy), 64'd0);

        // WAW against a pending destination.
        md_issue = 1'b1; md_issue_rd = 5'd12; id_valid = 1'b0;
        tick();
        md_issue = 1'b0;
        id_valid = 1'b1; id_rs_used = 2'b00; id_rd_we = 1'b1; id_rd_addr = 5'd12;
        #1;
        check("waw_stall", 64'(stall), 64'd1);
        id_rd_addr = 5'd13;
        #1;
        check("waw_other_rd", 64'(stall), 64'd0);

        // Structural hazard and simultaneous done/issue.
        do_reset();
        md_issue = 1'b1; md_issue_rd = 5'd10;
        tick();
        md_issue = 1'b0;
        id_valid = 1'b1; id_is_md = 1'b1; id_rd_we = 1'b1; id_rd_addr = 5'd11;
        #1;
        check("struct_stall", 64'(stall), 64'd1);
        id_valid = 1'b0; id_is_md = 1'b0; id_rd_we = 1'b0;
        md_done = 1'b1; md_done_rd = 5'd10; md_issue = 1'b1; md_issue_rd = 5'd11;
        tick();
        check("both_busy", 64'(md_busy), 64'd1);
        check("both_sb", 64'(sb_pending), 64'h800);
        md_done_rd = 5'd11;
        tick();
        check("same_reg_set_wins", 64'(sb_pending), 64'h800);
        md_issue = 1'b0; md_done_rd = 5'd20;
        tick();
        check("done_nonpending_sb", 64'(sb_pending), 64'h800);
        check("done_busy_clear", 64'(md_busy), 64'd0);
        md_done = 1'b0; md_issue = 1'b1; md_issue_rd = 5'd0;
        tick();
        md_issue = 1'b0;
        check("x0_never_set", 64'(sb_pending), 64'h800);
        check("x0_issue_busy", 64'(md_busy), 64'd1);

        // Flush kills the stall but leaves the scoreboard alone.
        id_valid = 1'b1; id_rs_addr = {5'd11, 5'd0}; id_rs_used = 2'b10; flush = 1'b1;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_bubble", 64'(bubble), 64'd0);
        tick();
        check("flush_sb", 64'(sb_pending), 64'h800);
        check("flush_busy", 64'(md_busy), 64'd1);
        check("flush_cnt", 64'(stall_cnt), 64'd0);
        flush = 1'b0;
        #1;
        check("unflushed_stall", 64'(stall), 64'd1);
        tick();

        // Reset mid-divide overrides a concurrent issue.
        rst_n = 1'b0; md_issue = 1'b1; md_issue_rd = 5'd15;
        tick();
        rst_n = 1'b1; md_issue = 1'b0; id_valid = 1'b0;
        check("rst_mid_sb", 64'(sb_pending), 64'd0);
        check("rst_mid_busy", 64'(md_busy), 64'd0);
        check("rst_mid_cnt", 64'(stall_cnt), 64'd0);

        // Counter saturation under a continuous load-use stall.
        do_reset();
        id_valid = 1'b1; id_rs_addr = {5'd7, 5'd1}; id_rs_used = 2'b11;
        id_ex_rd_addr = 5'd7; id_ex_mem_read = 1'b1;
        for (int c = 0; c < 14; c++) tick();
        check("cnt_14", 64'(stall_cnt), 64'd14);
        for (int c = 0; c < 6; c++) tick();
        check("cnt_saturated", 64'(stall_cnt), 64'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline forwarding logic: generates ALU operand forward selects for NUM_SRC source operands and owns all ID-stage stall decisions.
- Stall sources: load-use hazards; a register scoreboard tracking destinations of in-flight multi-cycle M-extension ops (div/rem); a single-issue structural hazard on the multi-cycle unit.
- Sits beside the ID and EX stages and drives PC/IF-ID hold and the ID/EX bubble.
- Keeps a saturating stall-cycle counter for performance analysis.

Parameters:
- NUM_SRC, 2, number of source operands checked (2 now, 3 for future fused ops).
- ADDR_W, 5, register address width; the scoreboard has 2**ADDR_W entries.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_rs_addr  in  NUM_SRC*ADDR_W  ID-stage source addresses, operand k at [k*ADDR_W +: ADDR_W]
- id_rs_used  in  NUM_SRC  operand k is actually read by the ID instruction
- id_rd_addr  in  ADDR_W  ID-stage destination
- id_rd_we  in  1  ID instruction writes rd
- id_is_md  in  1  ID instruction is a multi-cycle M op
- id_valid  in  1  ID holds a real instruction
- ex_rs_addr  in  NUM_SRC*ADDR_W  ID/EX source addresses
- id_ex_rd_addr  in  ADDR_W  ID/EX destination
- id_ex_mem_read  in  1  ID/EX instruction is a load
- ex_mem_rd_addr  in  ADDR_W  EX/MEM destination
- ex_mem_reg_write_en  in  1  EX/MEM writes a register
- mem_wb_rd_addr  in  ADDR_W  MEM/WB destination
- mem_wb_reg_write_en  in  1  MEM/WB writes a register
- md_issue  in  1  multi-cycle op accepted by the unit this cycle
- md_issue_rd  in  ADDR_W  its destination
- md_done  in  1  multi-cycle result written back this cycle
- md_done_rd  in  ADDR_W  destination written back
- flush  in  1  ID instruction is being killed (branch/jump)
- fwd_sel  out  2*NUM_SRC  per-operand select: 00 register file, 01 EX/MEM, 10 MEM/WB
- stall  out  1  hold PC and IF/ID
- bubble  out  1  insert NOP into ID/EX
- md_busy  out  1  multi-cycle unit occupied (registered)
- sb_pending  out  2**ADDR_W  registered scoreboard vector
- stall_cnt  out  CNT_W  saturating stall-cycle count

Behaviour:
- Reset (rst_n low at a clk edge): sb_pending=0, md_busy=0, stall_cnt=0. Combinational outputs follow from the reset state: stall=0 and bubble=0 unless inputs create a hazard. Reset overrides a concurrent md_issue or md_done.
- fwd_sel (combinational), per operand k:
  - 01 if ex_mem_reg_write_en, ex_mem_rd_addr!=0 and ex_mem_rd_addr equals the operand address.
  - Else 10 under the same test on mem_wb.
  - Else 00.
  - Register x0 is never forwarded.
- Load-use hazard: id_valid & id_ex_mem_read & id_ex_rd_addr!=0 & some k with id_rs_used[k] and address match.
- RAW scoreboard hazard: id_valid & some used k with sb_pending[addr]=1.
- WAW hazard: id_valid & id_rd_we & id_rd_addr!=0 & sb_pending[id_rd_addr].
- Structural hazard: id_valid & id_is_md & md_busy.
- stall = bubble = (any hazard) & ~flush. flush always wins; 0 cycles of latency.
- Scoreboard update at each clk edge:
  - md_done clears bit md_done_rd.
  - md_issue with md_issue_rd!=0 sets bit md_issue_rd.
  - Same register set and cleared in one cycle: set wins.
  - md_done for a non-pending register is a no-op.
  - Bit 0 is never set.
- md_busy: set on md_issue and cleared on md_done. If both occur in one cycle, md_busy stays 1.
- Pending checks use registered state only, with no same-cycle bypass of md_done. The dependent instruction is released the cycle after md_done, and its operand is read from the register file.
- stall_cnt increments by 1 on each cycle stall=1 and saturates at all-ones.
- flush does not modify scoreboard or md_busy: in-flight ops always complete.

Test Plan:
- Operand 0 matches both EX/MEM and MEM/WB rd=5 with both write enables high -> fwd_sel[1:0]=01. Drop ex_mem_reg_write_en -> 10. Set rd=0 -> 00.
- ID/EX load to x7 and ID add using x7 as rs2 -> stall=bubble=1 for exactly one cycle. Same case with id_rs_used[1]=0 -> no stall.
- md_issue rd=10, then ID reads x10 -> stall held until md_done rd=10. Stall drops on the following cycle and stall_cnt equals the number of stalled cycles.
- md_busy=1 and ID presents a second div -> structural stall. md_done and md_issue in the same cycle -> md_busy remains 1 and the new bit is set.
- Hazard present with flush=1 -> stall=0 and the scoreboard is unchanged. Assert rst_n=0 mid-divide -> sb_pending=0, md_busy=0, stall_cnt=0 next cycle.
- Force stall_cnt near all-ones with continuous stall -> counter holds at all-ones and does not wrap.
